// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: turns fetched ARK instruction words into registered regfile/ALU/mem/PC strobes,
// sequencing load waits, taken-jump fetch bubbles and halt; CTRL_PERF_CNT_EN adds a retired-instruction counter.
module ctrl_sequencer #(
    parameter int INSTR_W        = 9,
    parameter int OP_W           = 4,
    parameter int MEM_LAT        = 2,
    parameter int BRANCH_BUBBLES = 1,
    parameter int CNT_W          = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [INSTR_W-1:0]      InstIn,
    input  logic                    InstValid,
    input  logic                    CondIn,
    output logic                    InstReady,
    output logic [OP_W-1:0]         OpCode,
    output logic [INSTR_W-OP_W-1:0] Operand,
    output logic                    AluEn,
    output logic                    RegWrEn,
    output logic                    MemRdEn,
    output logic                    MemWrEn,
    output logic                    PcInc,
    output logic                    PcJump,
    output logic                    Busy,
    output logic                    Done
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]        InstCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_MEM_WAIT,
        S_BUBBLE,
        S_HALT
    } state_t;

    localparam int WAIT_MAX = (MEM_LAT > BRANCH_BUBBLES) ? MEM_LAT : BRANCH_BUBBLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] MEM_INIT = WAIT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] BUB_INIT = WAIT_W'((BRANCH_BUBBLES > 0) ? BRANCH_BUBBLES - 1 : 0);

    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;
    localparam logic [3:0] OP_NEQ   = 4'd14;
    localparam logic [3:0] OP_DONE  = 4'd15;

    state_t                    state_q;
    logic [WAIT_W-1:0]         wait_q;
    logic                      cond_q;
    logic [OP_W-1:0]           op_q;
    logic [INSTR_W-OP_W-1:0]   opd_q;
    logic                      alu_q, rw_q, mrd_q, mwr_q, inc_q, jmp_q, done_q;

    logic [OP_W-1:0]           op_in;
    logic [3:0]                op_lo;
    logic                      op_ext;

    assign op_in = InstIn[INSTR_W-1 -: OP_W];
    assign op_lo = op_in[3:0];

    // Opcodes beyond the 16-op set decode as a plain PC-advancing NOP.
    if (OP_W > 4) begin : g_wide_op
        assign op_ext = |op_in[OP_W-1:4];
    end else begin : g_narrow_op
        assign op_ext = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cond_q  <= 1'b0;
            op_q    <= '0;
            opd_q   <= '0;
            alu_q   <= 1'b0;
            rw_q    <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            inc_q   <= 1'b0;
            jmp_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            alu_q <= 1'b0;
            rw_q  <= 1'b0;
            mrd_q <= 1'b0;
            mwr_q <= 1'b0;
            inc_q <= 1'b0;
            jmp_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state_q <= S_ISSUE;
                        done_q  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (InstValid) begin
                        op_q  <= op_in;
                        opd_q <= InstIn[INSTR_W-OP_W-1:0];
                        if (op_ext) begin
                            inc_q <= 1'b1;
                        end else begin
                            case (op_lo)
                                4'd0, 4'd1, 4'd3, 4'd4: begin
                                    rw_q  <= 1'b1;
                                    inc_q <= 1'b1;
                                end
                                OP_STORE: begin
                                    mwr_q <= 1'b1;
                                    inc_q <= 1'b1;
                                end
                                OP_NEQ: begin
                                    alu_q  <= 1'b1;
                                    inc_q  <= 1'b1;
                                    cond_q <= CondIn;
                                end
                                OP_LOAD: begin
                                    mrd_q   <= 1'b1;
                                    rw_q    <= (MEM_LAT == 1);
                                    inc_q   <= (MEM_LAT == 1);
                                    wait_q  <= MEM_INIT;
                                    state_q <= S_MEM_WAIT;
                                end
                                OP_JUMP: begin
                                    if (cond_q) begin
                                        jmp_q  <= 1'b1;
                                        cond_q <= 1'b0;
                                        if (BRANCH_BUBBLES > 0) begin
                                            wait_q  <= BUB_INIT;
                                            state_q <= S_BUBBLE;
                                        end
                                    end else begin
                                        inc_q <= 1'b1;
                                    end
                                end
                                OP_DONE: begin
                                    state_q <= S_HALT;
                                    done_q  <= 1'b1;
                                end
                                default: begin
                                    alu_q <= 1'b1;
                                    rw_q  <= 1'b1;
                                    inc_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                // wait_q counts the load cycles still to come after the current one.
                S_MEM_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_ISSUE;
                    end else begin
                        mrd_q  <= 1'b1;
                        wait_q <= wait_q - 1'b1;
                        if (wait_q == WAIT_W'(1)) begin
                            rw_q  <= 1'b1;
                            inc_q <= 1'b1;
                        end
                    end
                end
                S_BUBBLE: begin
                    if (wait_q == '0) begin
                        state_q <= S_ISSUE;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign InstReady = (state_q == S_ISSUE);
    assign Busy      = (state_q == S_ISSUE) || (state_q == S_MEM_WAIT) || (state_q == S_BUBBLE);
    assign Done      = done_q;
    assign OpCode    = op_q;
    assign Operand   = opd_q;
    assign AluEn     = alu_q;
    assign RegWrEn   = rw_q;
    assign MemRdEn   = mrd_q;
    assign MemWrEn   = mwr_q;
    assign PcInc     = inc_q;
    assign PcJump    = jmp_q;

`ifdef CTRL_PERF_CNT_EN
    logic             retire_d;
    logic             clear_d;
    logic [CNT_W-1:0] cnt_q;

    // A load retires when its wait ends; everything else retires on accept.
    assign retire_d = ((state_q == S_ISSUE) && InstValid && !(!op_ext && (op_lo == OP_LOAD)))
                   || ((state_q == S_MEM_WAIT) && (wait_q == '0));
    assign clear_d  = Start && ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clear_d) begin
            cnt_q <= '0;
        end else if (retire_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign InstCount = cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios plus random streams, checked against a per-instruction
// schedule model built from the ARK sequencing rules.
module tb_ctrl_sequencer;

    localparam int INSTR_W = 9;
    localparam int OP_W    = 4;
    localparam int MEM_LAT = 2;
    localparam int BB      = 2;
`ifdef CTRL_PERF_CNT_EN
    localparam int CNT_W   = 2;
`else
    localparam int CNT_W   = 16;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    typedef struct packed {
        logic rdy, alu, rw, mrd, mwr, inc, jmp, busy, done;
        logic [3:0] op;
        logic [4:0] opd;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct packed {
        logic rdy, alu, rw, mrd, mwr, inc, jmp, ret;
    } rec_t;

    typedef struct packed {
        logic v;
        logic [8:0] w;
        logic c;
        logic s;
    } stim_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0;
    logic [INSTR_W-1:0] InstIn = '0;
    logic InstValid = 1'b0;
    logic CondIn = 1'b0;
    logic InstReady, AluEn, RegWrEn, MemRdEn, MemWrEn, PcInc, PcJump, Busy, Done;
    logic [OP_W-1:0] OpCode;
    logic [INSTR_W-OP_W-1:0] Operand;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] InstCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of expected per-cycle records scheduled at each accept.
    int   m_mode;
    rec_t m_q[$];
    logic [3:0] m_op;
    logic [4:0] m_opd;
    bit   m_cond;
    int   m_cnt;

    ctrl_sequencer #(
        .INSTR_W(INSTR_W), .OP_W(OP_W), .MEM_LAT(MEM_LAT), .BRANCH_BUBBLES(BB), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstIn(InstIn), .InstValid(InstValid),
        .CondIn(CondIn), .InstReady(InstReady), .OpCode(OpCode), .Operand(Operand),
        .AluEn(AluEn), .RegWrEn(RegWrEn), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
        .PcInc(PcInc), .PcJump(PcJump), .Busy(Busy), .Done(Done)
`ifdef CTRL_PERF_CNT_EN
        , .InstCount(InstCount)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic obs_t sample();
        obs_t o;
        o = '0;
        o.rdy = InstReady; o.alu = AluEn; o.rw = RegWrEn; o.mrd = MemRdEn; o.mwr = MemWrEn;
        o.inc = PcInc; o.jmp = PcJump; o.busy = Busy; o.done = Done;
        o.op = OpCode; o.opd = Operand;
`ifdef CTRL_PERF_CNT_EN
        o.cnt = InstCount;
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_op = '0; m_opd = '0; m_cond = 0; m_cnt = 0;
    endtask

    task automatic bump();
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    endtask

    task automatic model_accept(input logic [8:0] w, input logic c);
        int op;
        rec_t r;
        op = int'(w[8:5]);
        r = '0;
        m_op = w[8:5];
        m_opd = w[4:0];
        if (op == 2) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r = '0;
                r.mrd = 1'b1;
                if (i == MEM_LAT - 1) begin r.rw = 1'b1; r.inc = 1'b1; r.ret = 1'b1; end
                m_q.push_back(r);
            end
            return;
        end
        bump();
        if (op == 15) begin
            m_mode = M_HALT;
            return;
        end
        if (op == 6 && m_cond) begin
            m_cond = 0;
            for (int i = 0; i < ((BB > 0) ? BB : 1); i++) begin
                r = '0;
                r.jmp = (i == 0);
                r.rdy = (BB == 0);
                m_q.push_back(r);
            end
            return;
        end
        r.rdy = 1'b1;
        r.alu = (op >= 7 && op <= 14);
        r.rw  = (op <= 1) || (op == 3) || (op == 4) || (op >= 7 && op <= 13);
        r.mwr = (op == 5);
        r.inc = 1'b1;
        if (op == 14) m_cond = c;
        m_q.push_back(r);
    endtask

    // Drives one cycle of stimulus, returns observed and model-expected outputs for that cycle.
    task automatic cycle(input stim_t st, output obs_t o, output obs_t e);
        rec_t cur;
        InstValid = st.v; InstIn = st.w; CondIn = st.c; Start = st.s;
        cur = '0;
        if (m_mode == M_RUN) begin
            if (m_q.size() > 0) cur = m_q.pop_front();
            else cur.rdy = 1'b1;
        end
        e = '0;
        e.rdy = cur.rdy; e.alu = cur.alu; e.rw = cur.rw; e.mrd = cur.mrd; e.mwr = cur.mwr;
        e.inc = cur.inc; e.jmp = cur.jmp;
        e.busy = (m_mode == M_RUN);
        e.done = (m_mode == M_HALT);
        e.op = m_op; e.opd = m_opd;
`ifdef CTRL_PERF_CNT_EN
        e.cnt = CNT_W'(m_cnt);
`endif
        @(negedge Clk);
        o = sample();
        if (cur.ret) bump();
        if (m_mode != M_RUN && st.s) begin
            m_mode = M_RUN;
            m_cnt = 0;
        end else if (m_mode == M_RUN && cur.rdy && st.v) begin
            model_accept(st.w, st.c);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; InstValid = 1'b0; Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t o, e;
        @(negedge Clk);
        o = sample();
        n_cmp++;
        if (o !== '0) begin n_bad++; $display("FAIL reset_outputs got %h expected 0", o); end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cycle('{1'b1, 9'h085, 1'b0, 1'b0}, o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL reset_idle[%0d] got %h expected %h", i, o, e); end
            n_cmp++;
            if ({o.rdy, o.busy, o.rw} !== 3'b000) begin
                n_bad++; $display("FAIL reset_idle_rdy[%0d] got %b expected 000", i, {o.rdy, o.busy, o.rw});
            end
        end
    endtask

    task automatic test_stream();
        stim_t st[4];
        obs_t o, e;
        st = '{'{1'b0, 9'h000, 1'b0, 1'b1}, '{1'b1, 9'h1A0, 1'b0, 1'b0},
               '{1'b1, 9'h085, 1'b0, 1'b0}, '{1'b0, 9'h000, 1'b0, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            cycle(st[i], o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stream[%0d] got %h expected %h", i, o, e); end
            if (i == 1) begin
                n_cmp++;
                if (o.rdy !== 1'b1) begin n_bad++; $display("FAIL stream_ready got %b expected 1", o.rdy); end
            end
            if (i == 2) begin
                n_cmp++;
                if ({o.rdy, o.alu, o.rw, o.inc} !== 4'b1111) begin
                    n_bad++; $display("FAIL stream_xor got %b expected 1111", {o.rdy, o.alu, o.rw, o.inc});
                end
            end
            if (i == 3) begin
                n_cmp++;
                if ({o.alu, o.rw, o.inc, o.op} !== {3'b011, 4'd4}) begin
                    n_bad++; $display("FAIL stream_setreg got %h expected %h", {o.alu, o.rw, o.inc, o.op}, {3'b011, 4'd4});
                end
            end
        end
    endtask

    task automatic test_load();
        stim_t st[5];
        obs_t o, e;
        st = '{'{1'b1, 9'h043, 1'b0, 1'b0}, '{1'b1, 9'h085, 1'b0, 1'b0}, '{1'b1, 9'h085, 1'b0, 1'b0},
               '{1'b1, 9'h085, 1'b0, 1'b0}, '{1'b0, 9'h085, 1'b0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            cycle(st[i], o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL load[%0d] got %h expected %h", i, o, e); end
            if (i >= 1 && i <= 3) begin
                n_cmp++;
                if ({o.rdy, o.mrd, o.rw, o.inc} !== ((i == 1) ? 4'b0100 : (i == 2) ? 4'b0111 : 4'b1000)) begin
                    n_bad++; $display("FAIL load_seq[%0d] got %b", i, {o.rdy, o.mrd, o.rw, o.inc});
                end
            end
        end
    endtask

    task automatic test_branch();
        stim_t st[8];
        obs_t o, e;
        st = '{'{1'b1, 9'h1C0, 1'b1, 1'b0}, '{1'b1, 9'h0C3, 1'b0, 1'b0}, '{1'b1, 9'h085, 1'b0, 1'b0},
               '{1'b1, 9'h085, 1'b0, 1'b0}, '{1'b1, 9'h085, 1'b0, 1'b0}, '{1'b1, 9'h1C0, 1'b0, 1'b0},
               '{1'b1, 9'h0C3, 1'b1, 1'b0}, '{1'b0, 9'h000, 1'b0, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            cycle(st[i], o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL branch[%0d] got %h expected %h", i, o, e); end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if ({o.rdy, o.jmp, o.inc} !== ((i == 2) ? 3'b010 : 3'b000)) begin
                    n_bad++; $display("FAIL branch_bubble[%0d] got %b", i, {o.rdy, o.jmp, o.inc});
                end
            end
            if (i == 7) begin
                n_cmp++;
                if ({o.jmp, o.inc} !== 2'b01) begin
                    n_bad++; $display("FAIL branch_not_taken got %b expected 01", {o.jmp, o.inc});
                end
            end
        end
    endtask

    task automatic test_done();
        stim_t st[6];
        obs_t o, e;
        st = '{'{1'b1, 9'h1E0, 1'b0, 1'b1}, '{1'b1, 9'h085, 1'b0, 1'b0}, '{1'b1, 9'h085, 1'b0, 1'b0},
               '{1'b1, 9'h085, 1'b0, 1'b1}, '{1'b1, 9'h085, 1'b0, 1'b1}, '{1'b0, 9'h000, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            cycle(st[i], o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL done[%0d] got %h expected %h", i, o, e); end
            if (i >= 1 && i <= 4) begin
                n_cmp++;
                if ({o.done, o.rdy, o.busy} !== ((i <= 3) ? 3'b100 : 3'b011)) begin
                    n_bad++; $display("FAIL done_state[%0d] got %b", i, {o.done, o.rdy, o.busy});
                end
            end
            if (i == 5) begin
                n_cmp++;
                if ({o.rw, o.inc, o.busy, o.done} !== 4'b1110) begin
                    n_bad++; $display("FAIL done_resume got %b expected 1110", {o.rw, o.inc, o.busy, o.done});
                end
            end
        end
    endtask

    task automatic test_random();
        stim_t st;
        obs_t o, e;
        int bad_here;
        bad_here = 0;
        for (int i = 0; i < 600; i++) begin
            st.v = ($urandom_range(0, 3) != 0);
            st.w = 9'($urandom_range(0, 511));
            st.c = 1'($urandom_range(0, 1));
            st.s = ($urandom_range(0, 7) == 0);
            cycle(st, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                bad_here++;
                if (bad_here <= 10) $display("FAIL random[%0d] got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_midload();
        obs_t o, e;
        do_reset();
        cycle('{1'b0, 9'h000, 1'b0, 1'b1}, o, e);
        cycle('{1'b1, 9'h04F, 1'b0, 1'b0}, o, e);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL midload_accept got %h expected %h", o, e); end
        Reset = 1'b1;
        InstValid = 1'b0;
        #2;
        o = sample();
        n_cmp++;
        if (o !== '0) begin n_bad++; $display("FAIL midload_async got %h expected 0", o); end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle('{1'b1, 9'h085, 1'b0, 1'b0}, o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL midload_idle[%0d] got %h expected %h", i, o, e); end
            n_cmp++;
            if ({o.rdy, o.busy, o.done, o.mrd, o.rw} !== 5'b00000) begin
                n_bad++; $display("FAIL midload_quiet[%0d] got %b expected 00000", i, {o.rdy, o.busy, o.done, o.mrd, o.rw});
            end
        end
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perfcnt();
        obs_t o, e;
        do_reset();
        cycle('{1'b0, 9'h000, 1'b0, 1'b1}, o, e);
        for (int i = 0; i < 5; i++) begin
            cycle('{1'b1, 9'h085, 1'b0, 1'b0}, o, e);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL perf_run[%0d] got %h expected %h", i, o, e); end
        end
        cycle('{1'b1, 9'h1E0, 1'b0, 1'b0}, o, e);
        n_cmp++;
        if (o.cnt !== 2'd3) begin n_bad++; $display("FAIL perf_saturate got %0d expected 3", o.cnt); end
        cycle('{1'b0, 9'h000, 1'b0, 1'b1}, o, e);
        cycle('{1'b0, 9'h000, 1'b0, 1'b0}, o, e);
        n_cmp++;
        if (o.cnt !== 2'd0) begin n_bad++; $display("FAIL perf_clear got %0d expected 0", o.cnt); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_load();
        test_branch();
        test_done();
        test_random();
        test_reset_midload();
`ifdef CTRL_PERF_CNT_EN
        test_perfcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
